// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: fixed-priority machine-level interrupt controller.
// Level or rising-edge sources (selected by EDGE_MASK) are arbitrated,
// lowest index first. A claim produces a one-cycle INT_ pulse, and the
// source is then held in service until the core strobes int_rst (mret).
module irq_priority_ctrl #(
    parameter int          NUM_SRC   = 32,
    parameter logic [31:0] EDGE_MASK = 32'h0000_0000,
    parameter int          CAUSE_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] mie,
    input  logic [NUM_SRC-1:0] int_req,
    input  logic               int_rst,
    output logic               INT_,
    output logic [31:0]        mcause,
    output logic [NUM_SRC-1:0] int_fin,
    output logic               busy
);

    localparam logic [NUM_SRC-1:0] EDGE_SRC = EDGE_MASK[NUM_SRC-1:0];

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CAUSE_W-1:0]   mcause_q, mcause_d;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [NUM_SRC-1:0]   req_prev_q;

    logic [NUM_SRC-1:0]   rise;
    logic [NUM_SRC-1:0]   cand;
    logic [CAUSE_W-1:0]   sel;
    logic                 claim;

    // Edge detection and the enabled candidate set. Edge sources request
    // through their pending latch, level sources straight from the line.
    always_comb begin
        rise  = int_req & ~req_prev_q & EDGE_SRC;
        cand  = mie & ((EDGE_SRC & pending_q) | (~EDGE_SRC & int_req));
        claim = (state_q == S_IDLE) && (|cand);
    end

    // Priority encoder: scanning downwards leaves the lowest active index.
    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel = CAUSE_W'(i);
            end
        end
    end

    // Pending update: the claim clears the winner first so that a fresh
    // rising edge in the same cycle re-sets it and is not lost.
    always_comb begin
        pending_d = pending_q;
        if (claim && EDGE_SRC[sel]) begin
            pending_d[sel] = 1'b0;
        end
        pending_d = pending_d | rise;
        mcause_d  = claim ? sel : mcause_q;
    end

    // FSM next state: IDLE arbitrates, REQ is a single pulse cycle,
    // SERVICE waits for the core to complete the trap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (|cand)   state_d = S_REQ;
            S_REQ:                  state_d = S_SERVICE;
            S_SERVICE: if (int_rst) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // State, cause, pending latch and the delayed request lines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mcause_q   <= '0;
            pending_q  <= '0;
            req_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            mcause_q   <= mcause_d;
            pending_q  <= pending_d;
            req_prev_q <= int_req;
        end
    end

    // Outputs decoded from the state; the completion acknowledge is
    // combinational on int_rst and suppressed while reset is asserted.
    always_comb begin
        INT_    = 1'b0;
        busy    = 1'b0;
        int_fin = '0;
        case (state_q)
            S_REQ: begin
                INT_ = 1'b1;
                busy = 1'b1;
            end
            S_SERVICE: begin
                busy = 1'b1;
                if (int_rst && rst_n) begin
                    int_fin[mcause_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign mcause = {{(32 - CAUSE_W){1'b0}}, mcause_q};

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Bench for irq_priority_ctrl: a 32-source instance driven by directed
// vectors, and an 8-source instance driven randomly against a cycle model.
// Expected claims and completions are queued by the stimulus side and
// consumed by a monitor whenever the DUT pulses INT_ or drives int_fin.
module tb_irq_priority_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] mie, int_req;
    logic        int_rst;
    logic        INT_;
    logic [31:0] mcause, int_fin;
    logic        busy;

    logic [7:0]  mie8, req8, fin8;
    logic        irst8, int8, busy8;
    logic [31:0] mc8;

    irq_priority_ctrl #(.NUM_SRC(32), .EDGE_MASK(32'h0000_0005)) u_dut (
        .clk(clk), .rst_n(rst_n), .mie(mie), .int_req(int_req),
        .int_rst(int_rst), .INT_(INT_), .mcause(mcause),
        .int_fin(int_fin), .busy(busy)
    );

    irq_priority_ctrl #(.NUM_SRC(8), .EDGE_MASK(32'h0000_00F0)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .mie(mie8), .int_req(req8),
        .int_rst(irst8), .INT_(int8), .mcause(mc8),
        .int_fin(fin8), .busy(busy8)
    );

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    exp_t qi[$];
    exp_t qf[$];
    int   q8[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   rand_done = 1'b0;

    // reference model state for the 8-source instance
    int          ms   = 0;
    int          mmc  = 0;
    logic [7:0]  mpend = 8'h0;
    logic [7:0]  mreqd = 8'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string info);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (cycle %0d)", name, info, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic push_int(input int c, input logic [31:0] v);
        qi.push_back('{c, v});
    endtask

    task automatic push_fin(input int c, input logic [31:0] v);
        qf.push_back('{c, v});
    endtask

    // Cycle model of the 8-source instance (sources 4..7 edge, 0..3 level).
    initial begin
        logic [7:0] rise, np;
        bit         hit;
        int         pick;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                ms = 0; mmc = 0; mpend = 8'h0; mreqd = 8'h0;
            end else begin
                rise = req8 & ~mreqd & 8'hF0;
                np   = mpend;
                hit  = 1'b0;
                pick = 0;
                if (ms == 0) begin
                    for (int i = 0; i < 8; i++) begin
                        if (!hit && mie8[i] && ((i >= 4) ? mpend[i] : req8[i])) begin
                            hit  = 1'b1;
                            pick = i;
                        end
                    end
                    if (hit) begin
                        mmc = pick;
                        if (pick >= 4) np[pick] = 1'b0;
                        ms = 1;
                        q8.push_back(pick);
                    end
                end else if (ms == 1) begin
                    ms = 2;
                end else if (irst8) begin
                    ms = 0;
                end
                mpend = np | rise;
                mreqd = req8;
            end
        end
    end

    // Monitor: consumes queued expectations whenever a DUT presents output.
    initial begin
        exp_t       e;
        logic       prev_int, prev8;
        logic [7:0] ef;
        prev_int = 1'b0;
        prev8    = 1'b0;
        forever begin
            @(negedge clk);
            if (INT_) begin
                if (qi.size() == 0) begin
                    fail("unexpected_INT", $sformatf("INT_=1 with mcause=%0d, none expected", mcause));
                end else begin
                    e = qi.pop_front();
                    chk("claim_mcause", mcause, e.val);
                    chk("claim_cycle", cyc, e.cyc);
                end
            end
            if (int_fin != 32'h0) begin
                if (qf.size() == 0) begin
                    fail("unexpected_int_fin", $sformatf("int_fin=%0h, expected 0", int_fin));
                end else begin
                    e = qf.pop_front();
                    chk("int_fin_value", int_fin, e.val);
                    chk("int_fin_cycle", cyc, e.cyc);
                end
            end
            if (INT_ && prev_int) fail("INT_twice", "INT_ high two consecutive cycles");
            prev_int = INT_;

            ef = (ms == 2 && irst8 && rst_n) ? 8'(1 << mmc) : 8'h0;
            chk("u8_INT", 32'(int8), 32'(ms == 1));
            chk("u8_busy", 32'(busy8), 32'(ms != 0));
            chk("u8_int_fin", 32'(fin8), 32'(ef));
            if (int8) begin
                if (q8.size() == 0) fail("u8_unexpected_INT", $sformatf("mcause=%0d", mc8));
                else chk("u8_mcause", mc8, 32'(q8.pop_front()));
            end
            chk("u8_mcause_range", 32'(mc8 < 32'd8), 32'd1);
            chk("u8_fin_onehot0", 32'($onehot0(fin8)), 32'd1);
            if (int8 && prev8) fail("u8_INT_twice", "INT_ high two consecutive cycles");
            prev8 = int8;
        end
    end

    // Random stimulus for the 8-source instance.
    initial begin
        req8 = 8'h0; mie8 = 8'h0; irst8 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(3) == 0)  req8 = req8 ^ 8'($urandom);
            if ($urandom_range(15) == 0) mie8 = 8'($urandom);
            irst8 = ($urandom_range(3) == 0);
            @(posedge clk);
            #1;
        end
        rand_done = 1'b1;
    end

    // Directed stimulus for the 32-source instance.
    initial begin
        int c;
        rst_n = 1'b0; mie = 32'h0; int_req = 32'h0; int_rst = 1'b0;
        ticks(2);
        chk("rst_INT", 32'(INT_), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mcause", mcause, 32'd0);
        chk("rst_int_fin", int_fin, 32'd0);
        rst_n = 1'b1;
        tick();

        // level sources 3 and 5: 3 wins, then 5; level still high re-triggers
        c = cyc;
        mie = 32'hFFFF_FFFF; int_req = 32'h0000_0028;
        push_int(c + 1, 3);
        tick();
        chk("t1_busy_req", 32'(busy), 32'd1);
        ticks(4);
        int_rst = 1'b1; push_fin(c + 5, 32'h8);
        tick();
        int_rst = 1'b0; int_req = 32'h0000_0020; push_int(c + 7, 5);
        ticks(3);
        int_rst = 1'b1; push_fin(c + 9, 32'h20);
        tick();
        int_rst = 1'b0; push_int(c + 11, 5);
        tick();
        int_req = 32'h0;
        ticks(2);
        int_rst = 1'b1; push_fin(c + 13, 32'h20);
        tick();
        int_rst = 1'b0; mie = 32'h0;
        chk("t1_idle_busy", 32'(busy), 32'd0);
        ticks(3);

        // masked edge stays pending, fires once enabled, claimed only once
        c = cyc;
        int_req = 32'h1;
        tick();
        int_req = 32'h0;
        ticks(9);
        mie = 32'h1; push_int(c + 11, 0);
        ticks(3);
        int_rst = 1'b1; push_fin(c + 13, 32'h1);
        tick();
        int_rst = 1'b0;
        ticks(6);
        chk("t2_no_reclaim_busy", 32'(busy), 32'd0);

        // new edge in the claim cycle: pending survives, second claim follows
        mie = 32'h0;
        c = cyc;
        int_req = 32'h1;
        tick();
        int_req = 32'h0;
        tick();
        mie = 32'h1; int_req = 32'h1; push_int(c + 3, 0);
        ticks(3);
        int_rst = 1'b1; int_req = 32'h0; push_fin(c + 5, 32'h1);
        tick();
        int_rst = 1'b0; push_int(c + 7, 0);
        ticks(3);
        int_rst = 1'b1; push_fin(c + 9, 32'h1);
        tick();
        int_rst = 1'b0;
        ticks(5);

        // re-trigger: second edge during service, exactly two claims
        c = cyc;
        int_req = 32'h1; push_int(c + 2, 0);
        tick();
        int_req = 32'h0;
        ticks(3);
        int_req = 32'h1;
        tick();
        int_req = 32'h0;
        tick();
        int_rst = 1'b1; push_fin(c + 6, 32'h1); push_int(c + 8, 0);
        tick();
        int_rst = 1'b0;
        ticks(3);
        int_rst = 1'b1; push_fin(c + 10, 32'h1);
        tick();
        int_rst = 1'b0;
        ticks(6);
        mie = 32'h0;

        // stray completion in IDLE and REQ is ignored
        int_rst = 1'b1;
        chk("t4_fin_idle", int_fin, 32'h0);
        chk("t4_busy_idle", 32'(busy), 32'd0);
        tick();
        c = cyc;
        int_rst = 1'b0; mie = 32'h8; int_req = 32'h8; push_int(c + 1, 3);
        tick();
        int_rst = 1'b1;
        chk("t4_fin_req", int_fin, 32'h0);
        chk("t4_INT_req", 32'(INT_), 32'd1);
        tick();
        int_rst = 1'b0;
        chk("t4_busy_service", 32'(busy), 32'd1);
        tick();
        chk("t4_busy_still_service", 32'(busy), 32'd1);
        int_rst = 1'b1; int_req = 32'h0; push_fin(c + 3, 32'h8);
        tick();
        int_rst = 1'b0; mie = 32'h0;
        chk("t4_busy_done", 32'(busy), 32'd0);
        ticks(2);

        // reset during service with src2 pending: everything dropped
        c = cyc;
        mie = 32'h4; int_req = 32'h4; push_int(c + 2, 2);
        tick();
        int_req = 32'h0;
        ticks(3);
        int_req = 32'h4;
        tick();
        int_req = 32'h0;
        tick();
        rst_n = 1'b0; int_rst = 1'b1;
        chk("t5_fin_in_reset", int_fin, 32'h0);
        tick();
        rst_n = 1'b1; int_rst = 1'b0;
        chk("t5_INT", 32'(INT_), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_mcause", mcause, 32'd0);
        ticks(8);
        chk("t5_no_claim_busy", 32'(busy), 32'd0);

        // fresh edge after reset; mie cleared mid-service still completes
        c = cyc;
        int_req = 32'h4; push_int(c + 2, 2);
        tick();
        int_req = 32'h0;
        ticks(2);
        mie = 32'h0;
        tick();
        int_rst = 1'b1; push_fin(c + 4, 32'h4);
        tick();
        int_rst = 1'b0;
        ticks(3);

        for (int k = 0; k < 12000 && !rand_done; k++) tick();
        if (!rand_done) fail("rand_timeout", "random run did not finish in budget");
        ticks(2);
        chk("qi_drained", 32'(qi.size()), 32'd0);
        chk("qf_drained", 32'(qf.size()), 32'd0);
        chk("q8_drained", 32'(q8.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
